// File: rtl/switch_cfg_pkg.sv
// Shared definitions for the crossbar configuration controller.
package switch_cfg_pkg;

    // Commit sweep state: IDLE accepts loads and commit requests, CHECK walks the shadow bank.
    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } cfg_state_e;

    localparam int DEFAULT_N_PORTS = 16;

    // Low bit of port k's field inside a flat bus of width-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/switch_cfg_bank.sv
// One bank of per-output {input select, enable} registers.
// Supports a single-entry write port and a whole-bank parallel load;
// the shadow copy uses the former, the active copy the latter.
module switch_cfg_bank
    import switch_cfg_pkg::*;
#(
    parameter int N_PORTS = DEFAULT_N_PORTS,
    parameter int SEL_W   = $clog2(N_PORTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [SEL_W-1:0]         wr_port,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic                     wr_oen,
    input  logic                     load_all,
    input  logic [N_PORTS*SEL_W-1:0] load_sel,
    input  logic [N_PORTS-1:0]       load_oen,
    output logic [N_PORTS*SEL_W-1:0] sel_bus,
    output logic [N_PORTS-1:0]       oen_bus
);

    // Bank storage: a whole-bank load wins; single writes to ports beyond the switch are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_bus <= '0;
            oen_bus <= '0;
        end else if (load_all) begin
            sel_bus <= load_sel;
            oen_bus <= load_oen;
        end else if (wr_en && (int'(wr_port) < N_PORTS)) begin
            sel_bus[slice_lo(int'(wr_port), SEL_W) +: SEL_W] <= wr_sel;
            oen_bus[wr_port]                                <= wr_oen;
        end
    end

endmodule

// File: rtl/switch_cfg_ctrl.sv
// Crossbar configuration controller: host loads a shadow bank one port at a
// time, then a commit sweeps it for input contention and either copies it to
// the active bank driving the crossbar muxes or reports an error.
module switch_cfg_ctrl
    import switch_cfg_pkg::*;
#(
    parameter int N_PORTS     = DEFAULT_N_PORTS,
    parameter int SEL_W       = $clog2(N_PORTS),
    parameter bit ALLOW_MCAST = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [SEL_W-1:0]         load_port,
    input  logic [SEL_W-1:0]         load_sel,
    input  logic                     load_oen,
    input  logic                     conf_req,
    output logic [N_PORTS*SEL_W-1:0] inadd,
    output logic [N_PORTS-1:0]       out_en,
    output logic                     conf_busy,
    output logic                     conf_done,
    output logic                     conf_err,
    output logic                     load_rej
);

    cfg_state_e                 state;
    cfg_state_e                 next_state;
    logic [SEL_W-1:0]           idx;
    logic [(2**SEL_W)-1:0]      used;
    logic                       err_flag;
    logic [N_PORTS*SEL_W-1:0]   shadow_sel;
    logic [N_PORTS-1:0]         shadow_oen;
    logic [SEL_W-1:0]           cur_sel;
    logic                       cur_oen;
    logic                       hit;
    logic                       last;
    logic                       err_final;
    logic                       shadow_wr;
    logic                       active_load;

    assign shadow_wr   = load_en && (state == IDLE);
    assign cur_sel     = shadow_sel[slice_lo(int'(idx), SEL_W) +: SEL_W];
    assign cur_oen     = shadow_oen[idx];
    assign hit         = cur_oen && used[cur_sel];
    assign last        = (idx == SEL_W'(N_PORTS - 1));
    assign err_final   = err_flag || hit;
    assign active_load = (state == CHECK) && last && (ALLOW_MCAST || !err_final);

    switch_cfg_bank #(
        .N_PORTS (N_PORTS),
        .SEL_W   (SEL_W)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (shadow_wr),
        .wr_port  (load_port),
        .wr_sel   (load_sel),
        .wr_oen   (load_oen),
        .load_all (1'b0),
        .load_sel ('0),
        .load_oen ('0),
        .sel_bus  (shadow_sel),
        .oen_bus  (shadow_oen)
    );

    switch_cfg_bank #(
        .N_PORTS (N_PORTS),
        .SEL_W   (SEL_W)
    ) u_active (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (1'b0),
        .wr_port  ('0),
        .wr_sel   ('0),
        .wr_oen   (1'b0),
        .load_all (active_load),
        .load_sel (shadow_sel),
        .load_oen (shadow_oen),
        .sel_bus  (inadd),
        .oen_bus  (out_en)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a commit request starts the sweep, which ends after the last port.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (conf_req) next_state = CHECK;
            CHECK:   if (last)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        conf_busy = 1'b0;
        if (state == CHECK) begin
            conf_busy = 1'b1;
        end
    end

    // Sweep bookkeeping: one shadow entry per cycle, marking inputs already claimed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            used     <= '0;
            err_flag <= 1'b0;
        end else if (state == IDLE) begin
            if (conf_req) begin
                idx      <= '0;
                used     <= '0;
                err_flag <= 1'b0;
            end
        end else begin
            idx <= idx + 1'b1;
            if (cur_oen) begin
                used[cur_sel] <= 1'b1;
            end
            if (hit) begin
                err_flag <= 1'b1;
            end
        end
    end

    // Status pulses, each registered so it appears the cycle after its cause.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conf_done <= 1'b0;
            conf_err  <= 1'b0;
            load_rej  <= 1'b0;
        end else begin
            conf_done <= active_load;
            conf_err  <= (state == CHECK) && last && err_final;
            load_rej  <= load_en && (state == CHECK);
        end
    end

endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// Scoreboard bench for switch_cfg_ctrl: one instance without and one with
// multicast. Commits push the hand-computed result; per-instance monitors pop
// and compare whenever conf_done or conf_err pulses.
module tb_switch_cfg_ctrl;

    typedef struct {
        logic        done;
        logic        err;
        logic [63:0] inadd;
        logic [15:0] oen;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en0 = 1'b0;
    logic        conf_req0 = 1'b0;
    logic        load_en1 = 1'b0;
    logic        conf_req1 = 1'b0;
    logic [3:0]  load_port = '0;
    logic [3:0]  load_sel = '0;
    logic        load_oen = 1'b0;

    logic [63:0] inadd0, inadd1;
    logic [15:0] out_en0, out_en1;
    logic        conf_busy0, conf_busy1;
    logic        conf_done0, conf_done1;
    logic        conf_err0, conf_err1;
    logic        load_rej0, load_rej1;

    exp_t q0[$];
    exp_t q1[$];
    int   assertions = 0;
    int   failures = 0;

    switch_cfg_ctrl #(.N_PORTS(16), .ALLOW_MCAST(1'b0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en0),
        .load_port (load_port),
        .load_sel  (load_sel),
        .load_oen  (load_oen),
        .conf_req  (conf_req0),
        .inadd     (inadd0),
        .out_en    (out_en0),
        .conf_busy (conf_busy0),
        .conf_done (conf_done0),
        .conf_err  (conf_err0),
        .load_rej  (load_rej0)
    );

    switch_cfg_ctrl #(.N_PORTS(16), .ALLOW_MCAST(1'b1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en1),
        .load_port (load_port),
        .load_sel  (load_sel),
        .load_oen  (load_oen),
        .conf_req  (conf_req1),
        .inadd     (inadd1),
        .out_en    (out_en1),
        .conf_busy (conf_busy1),
        .conf_done (conf_done1),
        .conf_err  (conf_err1),
        .load_rej  (load_rej1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic busyOf(input int target);
        return (target == 0) ? conf_busy0 : conf_busy1;
    endfunction

    // Write one shadow entry; starts and ends just after a rising edge.
    task automatic applyStimulus(input int target, input logic [3:0] port,
                                 input logic [3:0] sel, input logic oen);
        load_port = port;
        load_sel  = sel;
        load_oen  = oen;
        if (target == 0) load_en0 = 1'b1;
        else             load_en1 = 1'b1;
        @(posedge clk);
        #1;
        load_en0 = 1'b0;
        load_en1 = 1'b0;
    endtask

    task automatic loadAll(input int target, input bit identity);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(target, 4'(k), identity ? 4'(k) : 4'd0, identity);
        end
    endtask

    task automatic startCommit(input int target, input exp_t e, input bit expect_pulse);
        if (expect_pulse) begin
            if (target == 0) q0.push_back(e);
            else             q1.push_back(e);
        end
        if (target == 0) conf_req0 = 1'b1;
        else             conf_req1 = 1'b1;
        @(posedge clk);
        #1;
        conf_req0 = 1'b0;
        conf_req1 = 1'b0;
    endtask

    // Count remaining busy cycles until the sweep ends, with a bounded wait.
    task automatic waitCommit(input int target, input int exp_busy, input string name);
        int cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busyOf(target)) cnt++;
            else break;
        end
        checkOutput(name, 64'(cnt), 64'(exp_busy));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the non-multicast instance.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!reset && (conf_done0 || conf_err0)) begin
            if (q0.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL dut0_unexpected_pulse: got done=%0b err=%0b, expected no pulse",
                         conf_done0, conf_err0);
            end else begin
                e = q0.pop_front();
                checkOutput("dut0_done", 64'(conf_done0), 64'(e.done));
                checkOutput("dut0_err", 64'(conf_err0), 64'(e.err));
                checkOutput("dut0_inadd", inadd0, e.inadd);
                checkOutput("dut0_out_en", 64'(out_en0), 64'(e.oen));
                checkOutput("dut0_busy_at_pulse", 64'(conf_busy0), 64'd0);
            end
        end
    end

    // Monitor for the multicast instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!reset && (conf_done1 || conf_err1)) begin
            if (q1.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL dut1_unexpected_pulse: got done=%0b err=%0b, expected no pulse",
                         conf_done1, conf_err1);
            end else begin
                e = q1.pop_front();
                checkOutput("dut1_done", 64'(conf_done1), 64'(e.done));
                checkOutput("dut1_err", 64'(conf_err1), 64'(e.err));
                checkOutput("dut1_inadd", inadd1, e.inadd);
                checkOutput("dut1_out_en", 64'(out_en1), 64'(e.oen));
                checkOutput("dut1_busy_at_pulse", 64'(conf_busy1), 64'd0);
            end
        end
    end

    initial begin
        exp_t e;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_inadd0", inadd0, 64'd0);
        checkOutput("rst_out_en0", 64'(out_en0), 64'd0);
        checkOutput("rst_busy0", 64'(conf_busy0), 64'd0);
        checkOutput("rst_done0", 64'(conf_done0), 64'd0);
        checkOutput("rst_err0", 64'(conf_err0), 64'd0);
        checkOutput("rst_rej0", 64'(load_rej0), 64'd0);
        checkOutput("rst_inadd1", inadd1, 64'd0);
        checkOutput("rst_out_en1", 64'(out_en1), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: reset in the middle of a sweep.
        $display("[TB] reset mid-sweep");
        loadAll(0, 1'b1);
        startCommit(0, e, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("t1_busy_before_reset", 64'(conf_busy0), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("t1_busy_in_reset", 64'(conf_busy0), 64'd0);
        checkOutput("t1_inadd_in_reset", inadd0, 64'd0);
        checkOutput("t1_out_en_in_reset", 64'(out_en0), 64'd0);
        checkOutput("t1_done_in_reset", 64'(conf_done0), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t1_busy_after", 64'(conf_busy0), 64'd0);
        checkOutput("t1_inadd_after", inadd0, 64'd0);

        // Test 2: identity configuration.
        $display("[TB] identity commit");
        loadAll(0, 1'b1);
        e = '{done: 1'b1, err: 1'b0, inadd: 64'hFEDCBA9876543210, oen: 16'hFFFF};
        startCommit(0, e, 1'b1);
        waitCommit(0, 16, "t2_busy_len");

        // Test 3: contention without multicast, then resolved by disabling port 9.
        $display("[TB] contention");
        loadAll(0, 1'b0);
        applyStimulus(0, 4'd3, 4'd5, 1'b1);
        applyStimulus(0, 4'd9, 4'd5, 1'b1);
        e = '{done: 1'b0, err: 1'b1, inadd: 64'hFEDCBA9876543210, oen: 16'hFFFF};
        startCommit(0, e, 1'b1);
        waitCommit(0, 16, "t3a_busy_len");
        checkOutput("t3a_inadd_kept", inadd0, 64'hFEDCBA9876543210);
        applyStimulus(0, 4'd9, 4'd5, 1'b0);
        e = '{done: 1'b1, err: 1'b0, inadd: 64'h0000_0050_0000_5000, oen: 16'h0008};
        startCommit(0, e, 1'b1);
        waitCommit(0, 16, "t3b_busy_len");

        // Test 4: multicast instance accepts shared inputs but still flags them.
        $display("[TB] multicast");
        applyStimulus(1, 4'd0, 4'd7, 1'b1);
        applyStimulus(1, 4'd1, 4'd7, 1'b1);
        applyStimulus(1, 4'd2, 4'd7, 1'b1);
        e = '{done: 1'b1, err: 1'b1, inadd: 64'h0000_0000_0000_0777, oen: 16'h0007};
        startCommit(1, e, 1'b1);
        waitCommit(1, 16, "t4_busy_len");

        // Test 5: load during the sweep is rejected and leaves the shadow bank alone.
        $display("[TB] load while busy");
        applyStimulus(0, 4'd4, 4'd6, 1'b1);
        checkOutput("t5_no_rej_idle", 64'(load_rej0), 64'd0);
        e = '{done: 1'b1, err: 1'b0, inadd: 64'h0000_0050_0006_5000, oen: 16'h0018};
        startCommit(0, e, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0, 4'd4, 4'd2, 1'b1);
        checkOutput("t5_load_rej", 64'(load_rej0), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("t5_load_rej_single", 64'(load_rej0), 64'd0);
        waitCommit(0, 11, "t5_busy_len");

        // Test 6: load and commit in the same cycle; extra request mid-sweep ignored.
        $display("[TB] load with commit");
        load_port = 4'd15;
        load_sel  = 4'd1;
        load_oen  = 1'b1;
        load_en0  = 1'b1;
        e = '{done: 1'b1, err: 1'b0, inadd: 64'h1000_0050_0006_5000, oen: 16'h8018};
        startCommit(0, e, 1'b1);
        load_en0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        conf_req0 = 1'b1;
        @(posedge clk);
        #1;
        conf_req0 = 1'b0;
        waitCommit(0, 10, "t6_busy_len");
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t6_no_second_sweep", 64'(conf_busy0), 64'd0);
        checkOutput("t6_inadd_final", inadd0, 64'h1000_0050_0006_5000);

        checkOutput("q0_drained", 64'(q0.size()), 64'd0);
        checkOutput("q1_drained", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/switch_cfg_ctrl.md
Name: switch_cfg_ctrl

Overview:
- Configuration controller for the NxN crossbar switch; the next generation of the per-output input-address register.
- Holds a shadow bank (one input-select plus enable per output port), loaded one port at a time.
- On a commit request, a sequential sweep checks the shadow bank for input contention, then either transfers it atomically to the active bank that drives the crossbar muxes, or rejects it.
- Sits between the host/config interface and the crossbar datapath.

Parameters:
- N_PORTS, 16, number of input ports and number of output ports (square switch); minimum 2.
- SEL_W, $clog2(N_PORTS), width of one input-select field.
- ALLOW_MCAST, 0. When 0, two enabled outputs selecting the same input make the commit fail. When 1, multicast is legal and the contention check is informational only.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write one shadow entry this cycle.
- load_port  in  SEL_W  output port being written.
- load_sel  in  SEL_W  input address for that output.
- load_oen  in  1  enable bit for that output.
- conf_req  in  1  commit request, sampled every cycle.
- inadd  out  N_PORTS*SEL_W  active input select per output; port k occupies bits [k*SEL_W +: SEL_W].
- out_en  out  N_PORTS  active per-output enable.
- conf_busy  out  1  high while a commit sweep is in progress.
- conf_done  out  1  one-cycle pulse: active bank updated.
- conf_err  out  1  one-cycle pulse: contention found.
- load_rej  out  1  one-cycle pulse: a load was dropped because the block was busy.

Behaviour:
- Reset (async, any time, including mid-sweep):
  - shadow and active banks cleared (all sel=0, all en=0).
  - inadd=0, out_en=0, conf_busy=0, conf_done=0, conf_err=0, load_rej=0.
  - FSM to IDLE; sweep index and used-input bitmap cleared.
- FSM states:
  - IDLE: conf_busy=0.
  - CHECK: conf_busy=1.
- IDLE:
  - load_en=1 writes shadow[load_port] <= {load_sel, load_oen} at the edge. load_port >= N_PORTS is ignored, no pulse.
  - conf_req=1 -> CHECK; idx<=0, used<=0, err_flag<=0.
  - Load and conf_req in the same cycle: the load is written first, and the sweep sees the new value.
- CHECK, one port per cycle, idx = 0..N_PORTS-1:
  - If shadow_en[idx] and used[shadow_sel[idx]], set err_flag.
  - If shadow_en[idx], set used[shadow_sel[idx]].
  - Disabled outputs never contend.
- End of sweep, at the edge with idx=N_PORTS-1, let err_final = err_flag OR (contention on this entry):
  - If ALLOW_MCAST=1 or err_final=0: active <= shadow and conf_done=1 for the next cycle.
  - If err_final=1: conf_err=1 for the next cycle.
  - If ALLOW_MCAST=0 and err_final=1: the active bank is unchanged and conf_done stays 0.
  - Return to IDLE.
- Latency:
  - conf_req sampled at edge E0; the active bank changes at edge E(N_PORTS).
  - conf_busy is high for exactly N_PORTS cycles.
  - conf_done/conf_err are high in the cycle after E(N_PORTS), while conf_busy is already 0.
- During CHECK:
  - load_en=1 does not modify the shadow bank; load_rej pulses the next cycle.
  - conf_req is ignored (no queueing).
- Outputs inadd/out_en are registered, glitch-free, and change only at a successful commit or reset.
- The shadow bank persists after a commit, so partial reloads followed by a recommit are legal.

Decomposition:
- Shared package switch_cfg_pkg:
  - state enum {IDLE, CHECK}.
  - Default N_PORTS.
  - Function for the flat-bus slice index.
- One natural sub-module: switch_cfg_bank. It holds a parametrised N_PORTS x (SEL_W+1) register bank with write port, flat read-out and whole-bank load. It is instantiated twice, as shadow and as active.

Test Plan (N_PORTS=16 unless stated):
1. Reset mid-sweep: load all 16 entries, assert conf_req, assert reset at sweep cycle 7 -> all outputs 0, conf_done never pulses, FSM IDLE.
2. Identity config: load port k sel=k en=1 for k=0..15, then conf_req -> conf_busy high exactly 16 cycles; inadd=0xFEDCBA9876543210; out_en=0xFFFF; conf_done single pulse; conf_err=0.
3. Contention, ALLOW_MCAST=0: ports 3 and 9 both sel=5 en=1, conf_req -> conf_err pulse; inadd/out_en keep the previous committed values; conf_done=0.
   - Same config with port 9 en=0 -> commit succeeds.
4. Multicast, ALLOW_MCAST=1: ports 0,1,2 sel=7 en=1 -> conf_done and conf_err both pulse; inadd slices 0..2 = 7.
5. Load during busy: load port 4 sel=2 at sweep cycle 3 -> load_rej pulse; after commit, port 4 still holds its pre-sweep value.
6. Load and conf_req in the same IDLE cycle (port 15 sel=1 en=1) -> committed inadd[63:60]=1; conf_req during CHECK is ignored, so exactly one conf_done is seen.
